memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE: MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs and resolves branches.
//   Runs a req/ack data-memory access with byte/half/word lanes, stalls upstream while the access is pending,
//   and registers the MEM/WB pipeline outputs.
// PARAMETERS: TIMEOUT  default 16  max WAIT cycles without dmem_ack before the access is aborted (>=1)
// PORTS:
//   Clk                in   1   pipeline clock, rising edge
//   Rst                in   1   asynchronous, active-high reset
//   ALUResult          in   32  effective byte address / ALU result from EX
//   ReadData2          in   32  store data from EX
//   RegDstAddress      in   5   destination register from EX
//   Zero               in   1   ALU zero flag
//   SignBit            in   1   ALU result sign flag
//   Branch             in   1   instruction is a conditional branch
//   BranchLogicOp      in   3   branch condition select
//   BitSel             in   2   access size: 00 word, 01 half, 10 byte, 11 = word
//   RegWrite           in   1   write-back enable
//   MemWrite           in   1   store
//   MemRead            in   1   load
//   MemToReg           in   1   WB selects load data
//   dmem_req           out  1   memory request, held until ack
//   dmem_we            out  1   1 = write
//   dmem_addr          out  32  {ALUResult[31:2],2'b00}
//   dmem_be            out  4   byte enables, bit n = bits[8n+7:8n]
//   dmem_wdata         out  32  lane-replicated store data
//   dmem_rdata         in   32  read data, valid with dmem_ack
//   dmem_ack           in   1   access complete; may arrive in the same cycle as req
//   PCSrc              out  1   branch taken (to IF)
//   Stall              out  1   freeze PC, IF/ID, ID/EX and EX/MEM
//   MemFault           out  1   one-cycle pulse: misaligned access or timeout
//   ReadData_out       out  32  MEM/WB: extended load data
//   ALUResult_out      out  32  MEM/WB: ALUResult
//   RegDstAddress_out  out  5   MEM/WB: destination register
//   RegWrite_out       out  1   MEM/WB: write enable (0 = bubble)
//   MemToReg_out       out  1   MEM/WB: MemToReg
// BEHAVIOUR:
// - Reset: state IDLE, cnt 0; every registered output 0. dmem_req, dmem_we, Stall and PCSrc are forced 0 while Rst=1.
//   Reset mid-access drops the request with no handshake completion.
// - PCSrc (comb) = Branch & cond. Conditions: 000 Zero, 001 !Zero, 010 !SignBit, 011 !SignBit&!Zero,
//   100 SignBit|Zero, 101 SignBit; 110 and 111 give 0.
// - op = MemRead|MemWrite; both set => write. dmem_we = MemWrite.
// - Misalignment: misaligned = (half & a[0]) | (word & a[1:0]!=0), where a = ALUResult[1:0].
// - Misaligned op: no request. Next cycle MemFault=1 and RegWrite_out=0.
// - Store lanes: byte => wdata={4{d[7:0]}}, be=1<<a. Half => {2{d[15:0]}}, be=a[1]?1100:0011. Word => be=1111.
// - Load: select the byte/half at a, then sign-extend to 32 bits. A word load passes through.
// - FSM IDLE/WAIT:
//   dmem_req = aligned op & (IDLE | (WAIT & cnt<TIMEOUT)). Stall = dmem_req & ~dmem_ack.
//   IDLE: req & ~ack -> WAIT, cnt=1. WAIT: ack -> IDLE; otherwise cnt++.
//   WAIT with cnt==TIMEOUT is the abort cycle: req=0, Stall=0. Next cycle MemFault=1 and bubble; state -> IDLE.
// - Latency: ack in the request cycle => 0 stall cycles. Ack k cycles later => Stall high exactly k cycles.
// - MEM/WB register on every edge:
//   Stall=1 => RegWrite_out<=0, other outputs hold.
//   Otherwise it loads its inputs; ReadData_out comes from dmem_rdata only on an acked load.
// TESTING:
// - lw a=0x100, rdata=0x8000_00FF, ack same cycle -> Stall 0; next cycle ReadData_out=0x8000_00FF, RegWrite_out=1.
// - sb a=0x103, ReadData2=0x1234_56AB, ack after 3 cycles -> be=1000, wdata=0xABABABAB, Stall high exactly 3 cycles.
// - lh a=0x102, rdata=0x8001_7FFF -> ReadData_out=0xFFFF_8001; lh at a=0x101 -> no req, MemFault pulse, RegWrite_out=0.
// - Branch=1, op=011, Zero=0, SignBit=0 -> PCSrc=1; same with SignBit=1 -> PCSrc=0.
// - TIMEOUT=4, lw, never ack -> Stall for 4 cycles, req low in the abort cycle, MemFault 1 cycle, FSM back in IDLE.
// - Assert Rst in WAIT cnt=2 -> same cycle req=0, Stall=0; all outputs 0; a fresh lw afterwards completes normally.

Source files
------------

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: branch resolve, req/ack data-memory access, MEM/WB register.
// Latency: 1 cycle to MEM/WB when acked in the request cycle; +k cycles when the ack arrives k cycles later.
// Backpressure: Stall freezes upstream while a request waits for ack; the access aborts after TIMEOUT wait cycles.
module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    input  logic [4:0]  RegDstAddress,
    input  logic        Zero,
    input  logic        SignBit,
    input  logic        Branch,
    input  logic [2:0]  BranchLogicOp,
    input  logic [1:0]  BitSel,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        MemToReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        PCSrc,
    output logic        Stall,
    output logic        MemFault,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  RegDstAddress_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [1:0]  a;
    logic        op, is_half, is_byte, is_word, misaligned, acc, abort;
    logic        cond, fault_nxt, load_done;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    assign a       = ALUResult[1:0];
    assign op      = MemRead | MemWrite;
    assign is_half = (BitSel == 2'b01);
    assign is_byte = (BitSel == 2'b10);
    assign is_word = ~is_half & ~is_byte;

    assign misaligned = (is_half & a[0]) | (is_word & (a != 2'b00));
    assign acc        = op & ~misaligned;
    assign abort      = (state == WAIT) && (cnt == TMO);

    assign dmem_req  = ~Rst & acc & ((state == IDLE) | ((state == WAIT) & (cnt < TMO)));
    assign Stall     = dmem_req & ~dmem_ack;
    assign dmem_we   = ~Rst & MemWrite;
    assign dmem_addr = {ALUResult[31:2], 2'b00};

    always_comb begin
        cond = 1'b0;
        case (BranchLogicOp)
            3'b000:  cond = Zero;
            3'b001:  cond = ~Zero;
            3'b010:  cond = ~SignBit;
            3'b011:  cond = ~SignBit & ~Zero;
            3'b100:  cond = SignBit | Zero;
            3'b101:  cond = SignBit;
            default: cond = 1'b0;
        endcase
    end

    assign PCSrc = ~Rst & Branch & cond;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        dmem_wdata = ReadData2;
        dmem_be    = 4'b1111;
        if (is_byte) begin
            dmem_wdata = {4{ReadData2[7:0]}};
            dmem_be    = 4'b0001 << a;
        end else if (is_half) begin
            dmem_wdata = {2{ReadData2[15:0]}};
            dmem_be    = a[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        lane_b = dmem_rdata[7:0];
        case (a)
            2'd1:    lane_b = dmem_rdata[15:8];
            2'd2:    lane_b = dmem_rdata[23:16];
            2'd3:    lane_b = dmem_rdata[31:24];
            default: lane_b = dmem_rdata[7:0];
        endcase
        lane_h   = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        if (is_byte)
            load_ext = {{24{lane_b[7]}}, lane_b};
        else if (is_half)
            load_ext = {{16{lane_h[15]}}, lane_h};
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (dmem_req && !dmem_ack) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT: begin
                if (abort || dmem_ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A misaligned op or an aborted access turns into a bubble plus a one-cycle fault flag.
    assign fault_nxt = (op & misaligned) | abort;
    assign load_done = dmem_req & dmem_ack & MemRead & ~MemWrite;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            MemFault          <= 1'b0;
            ReadData_out      <= '0;
            ALUResult_out     <= '0;
            RegDstAddress_out <= '0;
            RegWrite_out      <= 1'b0;
            MemToReg_out      <= 1'b0;
        end else begin
            MemFault <= fault_nxt;
            if (Stall) begin
                RegWrite_out <= 1'b0;
            end else begin
                ALUResult_out     <= ALUResult;
                RegDstAddress_out <= RegDstAddress;
                RegWrite_out      <= RegWrite & ~fault_nxt;
                MemToReg_out      <= MemToReg;
                if (load_done)
                    ReadData_out <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random instructions against a size/offset based reference model.
module tb_memory_stage;

    localparam int TMO = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] ALUResult, ReadData2, dmem_rdata;
    logic [4:0]  RegDstAddress;
    logic        Zero, SignBit, Branch, RegWrite, MemWrite, MemRead, MemToReg, dmem_ack;
    logic [2:0]  BranchLogicOp;
    logic [1:0]  BitSel;
    logic        dmem_req, dmem_we, PCSrc, Stall, MemFault, RegWrite_out, MemToReg_out;
    logic [31:0] dmem_addr, dmem_wdata, ReadData_out, ALUResult_out;
    logic [3:0]  dmem_be;
    logic [4:0]  RegDstAddress_out;

    memory_stage #(.TIMEOUT(TMO)) dut (
        .Clk(Clk), .Rst(Rst), .ALUResult(ALUResult), .ReadData2(ReadData2),
        .RegDstAddress(RegDstAddress), .Zero(Zero), .SignBit(SignBit), .Branch(Branch),
        .BranchLogicOp(BranchLogicOp), .BitSel(BitSel), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .PCSrc(PCSrc), .Stall(Stall), .MemFault(MemFault), .ReadData_out(ReadData_out),
        .ALUResult_out(ALUResult_out), .RegDstAddress_out(RegDstAddress_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Branch taken when the ALU result relation selected by the op holds.
    function automatic logic ref_pcsrc(input logic br, input logic [2:0] bop, input logic z, input logic s);
        logic eq0, lt0;
        eq0 = z;
        lt0 = s;
        case (bop)
            3'd0:    return br && eq0;
            3'd1:    return br && !eq0;
            3'd2:    return br && !lt0;
            3'd3:    return br && !lt0 && !eq0;
            3'd4:    return br && (lt0 || eq0);
            3'd5:    return br && lt0;
            default: return 1'b0;
        endcase
    endfunction

    // Issue one instruction; memory acks 'delay' cycles after the first request cycle.
    task automatic issue(input logic [31:0] alu, input logic [1:0] bsel, input logic mr, input logic mw,
                         input logic rw, input logic [31:0] d, input logic [31:0] rdat, input int delay);
        logic        op, mis, acc, timeout, fault;
        int          k, nbytes, exp_stall, stalls;
        logic [31:0] sh, exp_ext, exp_wd;
        logic [3:0]  exp_be;
        logic [4:0]  dst;
        @(negedge Clk);
        dst = 5'($urandom);
        ALUResult = alu; BitSel = bsel; MemRead = mr; MemWrite = mw; RegWrite = rw;
        MemToReg = mr; ReadData2 = d; dmem_rdata = rdat; RegDstAddress = dst;
        op      = mr | mw;
        k       = int'(alu[1:0]);
        nbytes  = (bsel == 2'b10) ? 1 : (bsel == 2'b01) ? 2 : 4;
        mis     = (k % nbytes) != 0;
        acc     = op && !mis;
        timeout = acc && (delay >= TMO);
        fault   = op && (mis || timeout);
        exp_stall = acc ? ((delay < TMO) ? delay : TMO) : 0;
        exp_be  = 4'(((1 << nbytes) - 1) << k);
        exp_wd  = (nbytes == 1) ? d[7:0] * 32'h0101_0101 :
                  (nbytes == 2) ? d[15:0] * 32'h0001_0001 : d;
        sh      = rdat >> (8 * k);
        exp_ext = (nbytes == 1) ? {{24{sh[7]}}, sh[7:0]} :
                  (nbytes == 2) ? {{16{sh[15]}}, sh[15:0]} : rdat;
        stalls = 0;
        for (int c = 0; c <= TMO + 1; c++) begin
            dmem_ack = acc && (c == delay);
            #1;
            chk("dmem_req", 32'(dmem_req), 32'(acc && c < TMO));
            chk("stall", 32'(Stall), 32'(acc && c < TMO && c != delay));
            if (c == 0) begin
                chk("pcsrc", 32'(PCSrc), 32'(ref_pcsrc(Branch, BranchLogicOp, Zero, SignBit)));
                chk("dmem_we", 32'(dmem_we), 32'(mw));
                chk("dmem_addr", dmem_addr, alu & 32'hFFFF_FFFC);
                if (acc && mw) begin
                    chk("dmem_be", 32'(dmem_be), 32'(exp_be));
                    chk("dmem_wdata", dmem_wdata, exp_wd);
                end
            end else begin
                chk("bubble_in_stall", 32'(RegWrite_out), 32'd0);
            end
            if (!Stall) break;
            stalls++;
            @(negedge Clk);
        end
        chk("stall_cycles", stalls, exp_stall);
        @(posedge Clk);
        #1;
        dmem_ack = 1'b0;
        if (mr && !mw && acc && !timeout) exp_rd = exp_ext;
        chk("memfault", 32'(MemFault), 32'(fault));
        chk("regwrite_out", 32'(RegWrite_out), 32'(rw && !fault));
        chk("aluresult_out", ALUResult_out, alu);
        chk("regdst_out", 32'(RegDstAddress_out), 32'(dst));
        chk("memtoreg_out", 32'(MemToReg_out), 32'(mr));
        chk("readdata_out", ReadData_out, exp_rd);
    endtask

    initial begin
        Rst = 1'b1; ALUResult = '0; ReadData2 = '0; dmem_rdata = '0; RegDstAddress = '0;
        Zero = 0; SignBit = 0; Branch = 0; BranchLogicOp = '0; BitSel = '0;
        RegWrite = 0; MemWrite = 0; MemRead = 0; MemToReg = 0; dmem_ack = 0;
        repeat (2) @(negedge Clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_fault", 32'(MemFault), 32'd0);
        chk("rst_regwrite", 32'(RegWrite_out), 32'd0);
        chk("rst_readdata", ReadData_out, 32'd0);
        Rst = 1'b0;

        // lw with same-cycle ack
        issue(32'h100, 2'b00, 1, 0, 1, 32'h0, 32'h8000_00FF, 0);
        chk("lw_value", ReadData_out, 32'h8000_00FF);
        // sb to the top byte, ack after 3 cycles
        issue(32'h103, 2'b10, 0, 1, 0, 32'h1234_56AB, 32'h0, 3);
        chk("sb_be", 32'(dmem_be), 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        // lh upper half, then misaligned lh
        issue(32'h102, 2'b01, 1, 0, 1, 32'h0, 32'h8001_7FFF, 1);
        chk("lh_value", ReadData_out, 32'hFFFF_8001);
        issue(32'h101, 2'b01, 1, 0, 1, 32'h0, 32'h8001_7FFF, 0);
        // branch condition 011 (greater than zero)
        Branch = 1; BranchLogicOp = 3'b011; Zero = 0; SignBit = 0;
        issue(32'h0, 2'b00, 0, 0, 1, 32'h0, 32'h0, 0);
        chk("br_gt_taken", 32'(PCSrc), 32'd1);
        SignBit = 1;
        issue(32'h4, 2'b00, 0, 0, 1, 32'h0, 32'h0, 0);
        chk("br_gt_not_taken", 32'(PCSrc), 32'd0);
        Branch = 0;
        // lw never acked: timeout, then fault must clear and a fresh lw must work
        issue(32'h200, 2'b00, 1, 0, 1, 32'h0, 32'h5555_AAAA, 1000);
        issue(32'h8, 2'b00, 0, 0, 0, 32'h0, 32'h0, 0);
        issue(32'h204, 2'b00, 1, 0, 1, 32'h0, 32'h1357_9BDF, 0);

        // reset while waiting with cnt=2
        @(negedge Clk);
        ALUResult = 32'h300; BitSel = 2'b00; MemRead = 1; MemWrite = 0; RegWrite = 1;
        Branch = 1; BranchLogicOp = 3'b000; Zero = 1; dmem_ack = 0;
        repeat (2) @(negedge Clk);
        chk("pre_rst_stall", 32'(Stall), 32'd1);
        #1 Rst = 1'b1;
        #1;
        chk("midrst_req", 32'(dmem_req), 32'd0);
        chk("midrst_stall", 32'(Stall), 32'd0);
        chk("midrst_pcsrc", 32'(PCSrc), 32'd0);
        chk("midrst_aluresult", ALUResult_out, 32'd0);
        chk("midrst_readdata", ReadData_out, 32'd0);
        chk("midrst_regwrite", 32'(RegWrite_out), 32'd0);
        chk("midrst_regdst", 32'(RegDstAddress_out), 32'd0);
        @(negedge Clk);
        MemRead = 0; Branch = 0; Rst = 1'b0;
        exp_rd = '0;
        issue(32'h300, 2'b00, 1, 0, 1, 32'h0, 32'hCAFE_F00D, 2);
        chk("post_rst_lw", ReadData_out, 32'hCAFE_F00D);

        for (int i = 0; i < 60; i++) begin
            Branch = 1'($urandom); BranchLogicOp = 3'($urandom);
            Zero = 1'($urandom); SignBit = 1'($urandom);
            issue($urandom, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, int'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
